// File: rtl/thr_alarm_pkg.sv
// thr_alarm_pkg: shared types and constants for the threshold alarm block.
//   state_t  - alarm FSM states (IDLE, ARMING, ALARM, CLEARING)
//   cmp_t    - one-hot comparison result {G, E, L}
//   EVT_SAT  - saturation value of the alarm event counter
package thr_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        ALARM,
        CLEARING
    } state_t;

    typedef enum logic [2:0] {
        CMP_G = 3'b100,
        CMP_E = 3'b010,
        CMP_L = 3'b001
    } cmp_t;

    localparam logic [7:0] EVT_SAT = 8'hFF;

endpackage

// File: rtl/thr_alarm_fsm_mag_cmp4.sv
// mag_cmp4: combinational unsigned 4-bit magnitude comparator.
// Ports:
//   a    in  4  sample
//   b    in  4  threshold
//   cmp  out 3  one-hot result using the cmp_t encoding (CMP_G/CMP_E/CMP_L)
module mag_cmp4
    import thr_alarm_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [2:0] cmp
);

    always_comb begin
        cmp = CMP_E;
        if (a > b)
            cmp = CMP_G;
        else if (a < b)
            cmp = CMP_L;
    end

endmodule

// File: rtl/thr_alarm_fsm.sv
// thr_alarm_fsm: sequential threshold alarm with sample-count hysteresis.
// The alarm sets after N_CONSEC consecutive samples above the threshold and
// clears after N_CONSEC consecutive samples below it; equal samples hold.
// Parameters:
//   N_CONSEC  qualifying samples needed to set/clear (1..15)
//   THR_RST   threshold value after reset
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid, in_data sample strobe and 4-bit unsigned sample
//   thr_load, thr_data threshold update strobe and value
//   alarm             registered alarm level
//   alarm_set/clr     one-cycle pulses on alarm assert/deassert
//   run_cnt           current consecutive-sample count
//   event_cnt         saturating count of alarm_set pulses
//   thr               current threshold
// Build option:
//   THR_ALARM_STICKY_EN  when defined, the alarm latches until reset.
module thr_alarm_fsm
    import thr_alarm_pkg::*;
#(
    parameter int unsigned N_CONSEC = 3,
    parameter logic [3:0]  THR_RST  = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic       thr_load,
    input  logic [3:0] thr_data,
    output logic       alarm,
    output logic       alarm_set,
    output logic       alarm_clr,
    output logic [3:0] run_cnt,
    output logic [7:0] event_cnt,
    output logic [3:0] thr
);

    localparam logic [3:0] N_RUN = 4'(N_CONSEC);

    state_t     state;
    logic [2:0] cmp_res;
    logic       is_g;
    logic       is_l;
    logic [3:0] run_inc;
    logic [7:0] evt_next;

    // Compares against the registered threshold, so a same-cycle load
    // only affects later samples.
    mag_cmp4 u_cmp (
        .a   (in_data),
        .b   (thr),
        .cmp (cmp_res)
    );

    always_comb begin
        is_g     = (cmp_res == CMP_G);
        is_l     = (cmp_res == CMP_L);
        run_inc  = run_cnt + 4'd1;
        evt_next = (event_cnt == EVT_SAT) ? event_cnt : event_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            alarm_set <= 1'b0;
            alarm_clr <= 1'b0;
            run_cnt   <= '0;
            event_cnt <= '0;
            thr       <= THR_RST;
        end else begin
            alarm_set <= 1'b0;
            alarm_clr <= 1'b0;

            if (thr_load)
                thr <= thr_data;

            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (is_g) begin
                            if (N_CONSEC == 1) begin
                                state     <= ALARM;
                                alarm     <= 1'b1;
                                alarm_set <= 1'b1;
                                run_cnt   <= '0;
                                event_cnt <= evt_next;
                            end else begin
                                state   <= ARMING;
                                run_cnt <= 4'd1;
                            end
                        end
                    end
                    ARMING: begin
                        if (is_g) begin
                            if (run_inc == N_RUN) begin
                                state     <= ALARM;
                                alarm     <= 1'b1;
                                alarm_set <= 1'b1;
                                run_cnt   <= '0;
                                event_cnt <= evt_next;
                            end else begin
                                run_cnt <= run_inc;
                            end
                        end else if (is_l) begin
                            state   <= IDLE;
                            run_cnt <= '0;
                        end
                    end
                    ALARM: begin
`ifdef THR_ALARM_STICKY_EN
                        // Latched until reset: low samples are ignored.
                        state <= ALARM;
`else
                        if (is_l) begin
                            if (N_CONSEC == 1) begin
                                state     <= IDLE;
                                alarm     <= 1'b0;
                                alarm_clr <= 1'b1;
                                run_cnt   <= '0;
                            end else begin
                                state   <= CLEARING;
                                run_cnt <= 4'd1;
                            end
                        end
`endif
                    end
                    CLEARING: begin
                        if (is_l) begin
                            if (run_inc == N_RUN) begin
                                state     <= IDLE;
                                alarm     <= 1'b0;
                                alarm_clr <= 1'b1;
                                run_cnt   <= '0;
                            end else begin
                                run_cnt <= run_inc;
                            end
                        end else if (is_g) begin
                            state   <= ALARM;
                            run_cnt <= '0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        alarm   <= 1'b0;
                        run_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
